// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter with tenure limit driving a shared 4:1 mux select
module mux4_rr_arbiter #(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nx;
    logic [3:0]         gnt_nx;
    logic [1:0]         sel_nx;
    logic [1:0]         last, last_nx;
    logic               busy_nx;
    logic               timeout_nx;
    logic [CNT_W-1:0]   hold_cnt, hold_nx;
    logic [1:0]         winner;
    logic [1:0]         idx;
    logic               any_req;
    logic               owner_req;
    logic               at_limit;

    assign any_req   = |req;
    assign owner_req = req[sel];
    assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Scan from the farthest candidate back to last+1 so the nearest requester wins;
    // the previous owner (offset 4 wraps to last) is therefore lowest priority.
    always_comb begin
        winner = last;
        idx    = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        sel_nx     = sel;
        busy_nx    = busy;
        timeout_nx = 1'b0;
        hold_nx    = hold_cnt;
        last_nx    = last;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = GRANT;
                    gnt_nx   = 4'b0001 << winner;
                    sel_nx   = winner;
                    busy_nx  = 1'b1;
                    hold_nx  = '0;
                    last_nx  = winner;
                end
            end
            GRANT: begin
                if (!owner_req || at_limit) begin
                    timeout_nx = owner_req;
                    if (any_req) begin
                        gnt_nx   = 4'b0001 << winner;
                        sel_nx   = winner;
                        busy_nx  = 1'b1;
                        hold_nx  = '0;
                        last_nx  = winner;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = 4'b0000;
                        busy_nx  = 1'b0;
                        hold_nx  = '0;
                    end
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 4'b0000;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'b00;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last     <= 2'd3;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            sel      <= sel_nx;
            busy     <= busy_nx;
            timeout  <= timeout_nx;
            hold_cnt <= hold_nx;
            last     <= last_nx;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    localparam int CNT_W    = 4;
    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    mux4_rr_arbiter #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int m_owner;
    int m_cnt;
    int m_last;
    int m_sel;
    int m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++) begin
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 3;
        m_sel   = 0;
        m_to    = 0;
        sb.delete();
    endtask

    // Reference behaviour for one edge; the expected post-edge outputs go to the scoreboard.
    task automatic model_edge(input logic [3:0] r);
        exp_t e;
        int   w;
        bit   handoff;
        m_to    = 0;
        handoff = 0;
        if (m_owner < 0) begin
            handoff = (r != 4'b0000);
        end else if (!r[m_owner]) begin
            handoff = 1;
        end else if (m_cnt == MAX_HOLD - 1) begin
            handoff = 1;
            m_to    = 1;
        end else begin
            m_cnt++;
        end
        if (handoff) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_last  = w;
                m_cnt   = 0;
            end else begin
                m_owner = -1;
            end
        end
        e.gnt     = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel     = 2'(m_sel);
        e.busy    = (m_owner >= 0);
        e.timeout = 1'(m_to);
        sb.push_back(e);
    endtask

    task automatic step(input logic [3:0] r);
        exp_t e;
        req = r;
        model_edge(r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("sel", 32'(sel), 32'(e.sel));
            check("busy", 32'(busy), 32'(e.busy));
            check("timeout", 32'(timeout), 32'(e.timeout));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_sel", 32'(sel), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_timeout", 32'(timeout), 32'd0);
            req = ~req;
        end
        req   = 4'b0000;
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [3:0] g_hist [0:39];
    logic       t_hist [0:39];
    int         order [0:4];
    int         n_grants;
    int         idle_cycles;
    int         n_to;
    int         n_starts;
    int         busy_low;
    logic [3:0] prev_gnt;
    logic [3:0] r;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #2;
        check("async_rst_gnt", 32'(gnt), 32'd0);

        // Reset with requests toggling, then async drop mid-grant
        do_reset();
        step(4'b0010);
        step(4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_drop_gnt", 32'(gnt), 32'd0);
        check("async_drop_busy", 32'(busy), 32'd0);
        do_reset();

        // Single requester
        n_to = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b0100);
            check("single_gnt", 32'(gnt), 32'h4);
            check("single_sel", 32'(sel), 32'd2);
            n_to += int'(timeout);
        end
        step(4'b0000);
        check("single_idle", 32'(gnt), 32'd0);
        check("single_no_timeout", 32'(n_to), 32'd0);
        step(4'b0000);

        // Fairness: each owner drops after two cycles of grant
        do_reset();
        n_grants    = 0;
        idle_cycles = 0;
        prev_gnt    = 4'b0000;
        for (int i = 0; i < 40 && n_grants < 5; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_cnt == 1) r[m_owner] = 1'b0;
            step(r);
            if (n_grants > 0 && !busy) idle_cycles++;
            if (gnt != prev_gnt && gnt != 4'b0000) begin
                order[n_grants] = int'(sel);
                n_grants++;
            end
            prev_gnt = gnt;
        end
        check("fair_count", 32'(n_grants), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("fair_order", 32'(order[i]), 32'(i % 4));
        end
        check("fair_idle", 32'(idle_cycles), 32'd0);

        // Preempt between two holders
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(4'b0011);
            g_hist[i] = gnt;
            t_hist[i] = timeout;
        end
        check("pre_first", 32'(g_hist[0]), 32'h1);
        check("pre_last0", 32'(g_hist[15]), 32'h1);
        check("pre_hand1", 32'(g_hist[16]), 32'h2);
        check("pre_to1", 32'(t_hist[16]), 32'd1);
        check("pre_to_pulse", 32'(t_hist[17]), 32'd0);
        check("pre_last1", 32'(g_hist[31]), 32'h2);
        check("pre_hand0", 32'(g_hist[32]), 32'h1);
        check("pre_to2", 32'(t_hist[32]), 32'd1);

        // Sole requester repeatedly preempted and re-granted
        do_reset();
        n_to     = 0;
        n_starts = 0;
        busy_low = 0;
        prev_gnt = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            step(4'b1000);
            if (timeout) n_to++;
            if (prev_gnt == 4'b0000 || timeout) n_starts++;
            if (!busy) busy_low++;
            prev_gnt = gnt;
        end
        check("sole_starts", 32'(n_starts), 32'd3);
        check("sole_timeouts", 32'(n_to), 32'd2);
        check("sole_busy", 32'(busy_low), 32'd0);
        step(4'b0000);

        // Release coincident with new requests, last=2
        do_reset();
        step(4'b0100);
        step(4'b0100);
        step(4'b1001);
        check("sim_gnt", 32'(gnt), 32'h8);
        check("sim_sel", 32'(sel), 32'd3);
        step(4'b1001);
        step(4'b0001);
        check("sim_next_gnt", 32'(gnt), 32'h1);
        check("sim_next_sel", 32'(sel), 32'd0);
        step(4'b0000);
        step(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
